// File: rtl/apb_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// apb_master_ctrl_if
//   Bundles the upstream request/response handshake and the APB segment
//   signals of the APB master sequencer.
//
//   Upstream side : req_valid/req_ready/req_write/req_addr/req_wdata in,
//                   rsp_valid/rsp_rdata/rsp_err out (no back-pressure).
//   APB side      : psel[15:0] (one-hot), penable, pwrite, paddr, pwdata out,
//                   prdata, pready, pslverr in (already muxed by slave).
//
//   modport master : the sequencer's view.
//   modport slave  : the view of whatever sits around it (bridge + slaves).
// ---------------------------------------------------------------------------
interface apb_master_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic [15:0] psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      input  prdata, pready, pslverr,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      output prdata, pready, pslverr,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_master_ctrl.sv
// ---------------------------------------------------------------------------
// apb_master_ctrl
//   APB master sequencer. Accepts single-beat read/write requests, decodes
//   one of 16 slaves, runs the SETUP/ACCESS protocol and returns read data
//   plus an error flag as a one-cycle response pulse.
//
// Ports
//   pclk  : clock, all logic on the rising edge
//   prst  : asynchronous active-high reset
//   bus   : apb_master_ctrl_if.master (request, response and APB signals)
//
// Parameters
//   BASE_ADDR   : address bits [31:12] of the peripheral window; only the
//                 bits above the slave index field take part in the decode
//   SEL_LSB     : lowest bit of the 4-bit slave index in req_addr
//   TIMEOUT_CYC : ACCESS-phase wait limit (only with APB_TIMEOUT_EN)
//
// Configuration
//   `define APB_TIMEOUT_EN : abort a transfer whose slave holds pready low
//                            for TIMEOUT_CYC ACCESS cycles. Without it the
//                            ACCESS phase waits indefinitely.
//
// Every output comes straight from a flop; the control flops are loaded
// from the decoded next state so they line up with the state register.
// ---------------------------------------------------------------------------
module apb_master_ctrl #(
   parameter logic [19:0] BASE_ADDR   = 20'h4000_0,
   parameter int          SEL_LSB     = 12,
   parameter int          TIMEOUT_CYC = 255
) (
   input  logic              pclk,
   input  logic              prst,
   apb_master_ctrl_if.master bus
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   localparam int          TAG_LSB   = SEL_LSB + 4;
   localparam logic [31:0] BASE_FULL = {BASE_ADDR, 12'h000};

   state_t      state_q, state_d;

   logic        req_ready_q, req_ready_d;
   logic        penable_q, penable_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] psel_q, psel_d;

   logic        pwrite_q;
   logic [31:0] paddr_q;
   logic [31:0] pwdata_q;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;

   logic        hit;
   logic [3:0]  sel_idx;
   logic        timeout;

   assign hit     = (bus.req_addr[31:TAG_LSB] == BASE_FULL[31:TAG_LSB]);
   assign sel_idx = bus.req_addr[SEL_LSB+3:SEL_LSB];

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [CNT_W-1:0] wait_cnt_q;

   // Held at zero outside ACCESS, so it is already clear on entry.
   always_ff @(posedge pclk or posedge prst) begin
      if (prst)
         wait_cnt_q <= '0;
      else if (state_q != ACCESS)
         wait_cnt_q <= '0;
      else if (!bus.pready)
         wait_cnt_q <= wait_cnt_q + 1'b1;
   end

   // This low-ready cycle is the one that takes the count to the limit;
   // pready high in the same cycle completes normally instead.
   assign timeout = (state_q == ACCESS) && !bus.pready &&
                    (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign timeout = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge pclk or posedge prst) begin
      if (prst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // NOTE: each always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.req_valid) state_d = hit ? SETUP : RESP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (bus.pready || timeout) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready_d = (state_d == IDLE);
      penable_d   = (state_d == ACCESS);
      rsp_valid_d = (state_d == RESP);
      psel_d      = '0;
      if (state_q == IDLE && state_d == SETUP)
         psel_d = 16'b1 << sel_idx;
      else if (state_d == ACCESS)
         psel_d = psel_q;
   end

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         req_ready_q <= 1'b1;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         psel_q      <= '0;
      end else begin
         req_ready_q <= req_ready_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         psel_q      <= psel_d;
      end
   end

   // Transfer attributes change only on acceptance; response fields only on
   // completion, so both hold their values in between.
   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         if (state_q == IDLE && bus.req_valid) begin
            pwrite_q <= bus.req_write;
            paddr_q  <= bus.req_addr;
            pwdata_q <= bus.req_wdata;
            if (!hit) begin
               rsp_err_q   <= 1'b1;
               rsp_rdata_q <= '0;
            end
         end
         if (state_q == ACCESS) begin
            if (bus.pready) begin
               rsp_err_q   <= bus.pslverr;
               rsp_rdata_q <= pwrite_q ? 32'h0 : bus.prdata;
            end else if (timeout) begin
               rsp_err_q   <= 1'b1;
               rsp_rdata_q <= '0;
            end
         end
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;

endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

APB master sequencer for the peripheral subsystem. Takes single-beat read/write requests from the upstream bus-bridge side, decodes the target among 16 APB slaves, and drives the SETUP/ACCESS protocol. It then returns read data, which arrives through the existing 16-way PRDATA mux, together with a completion status. It is the sole driver of PSEL, PENABLE, PADDR, PWRITE and PWDATA on the APB segment.

## Interface
- `BASE_ADDR`, default 20'h4000_0, compared against `REQ_ADDR[31:16]`. Only the upper `32-(SEL_LSB+4)` bits are used.
- `SEL_LSB`, default 12. `REQ_ADDR[SEL_LSB+3:SEL_LSB]` selects the slave index 0..15.
- `TIMEOUT_CYC`, default 255. Maximum ACCESS-phase cycles before abort; used only with `APB_TIMEOUT_EN`.
- `PCLK  in  1` clock; all logic rises on the posedge.
- `PRST  in  1` reset, asynchronous, active-high.
- `REQ_VALID  in  1` request present.
- `REQ_READY  out  1` controller can accept a request.
- `REQ_WRITE  in  1` 1 = write, 0 = read.
- `REQ_ADDR  in  32` byte address.
- `REQ_WDATA  in  32` write data.
- `RSP_VALID  out  1` one-cycle completion pulse.
- `RSP_RDATA  out  32` read data; 0 for writes and errors.
- `RSP_ERR  out  1` completion error; qualified by `RSP_VALID`.
- `PSEL  out  16` one-hot slave select; feeds the slaves and the PRDATA mux.
- `PENABLE  out  1` ACCESS-phase indicator.
- `PWRITE  out  1` transfer direction.
- `PADDR  out  32` transfer address.
- `PWDATA  out  32` write data.
- `PRDATA  in  32` muxed read data.
- `PREADY  in  1` muxed slave ready.
- `PSLVERR  in  1` muxed slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - `REQ_READY`=1.
  - On `REQ_VALID`, latch write flag, address and wdata into `PWRITE`, `PADDR` and `PWDATA`.
  - Decode hit (`REQ_ADDR` upper bits equal `BASE_ADDR`): go to SETUP.
  - Decode miss: go to RESP with error latched. No APB cycle occurs and PSEL stays 0.
- **SETUP**
  - `PSEL`=1<<index, `PENABLE`=0, `REQ_READY`=0.
  - Always goes to ACCESS next cycle.
- **ACCESS**
  - `PSEL` is held and `PENABLE`=1.
  - While `PREADY`=0, stay in ACCESS; PADDR, PWDATA, PWRITE and PSEL are stable.
  - When `PREADY`=1: capture `PSLVERR` into the error flag. For reads, capture `PRDATA`; for writes, capture 0. Go to RESP.
- **RESP**
  - `PSEL`=0, `PENABLE`=0.
  - `RSP_VALID`=1 for exactly one cycle with `RSP_RDATA`/`RSP_ERR`. Then go to IDLE.
  - The upstream side must always accept the response; there is no back-pressure.
- PADDR, PWDATA and PWRITE hold their last values between transfers and change only on acceptance.
- `RSP_RDATA` holds its value until the next completion.
- If PSLVERR is asserted on a read, `RSP_RDATA` still carries the captured PRDATA, and `RSP_ERR`=1.
- Reset mid-transfer: the in-flight request is dropped with no response. The FSM returns to IDLE immediately.

## Timing
- Reset values (asynchronous on PRST):
  - state=IDLE, `REQ_READY`=1.
  - `RSP_VALID`=0, `RSP_ERR`=0, `RSP_RDATA`=0.
  - `PSEL`=0, `PENABLE`=0, `PWRITE`=0, `PADDR`=0, `PWDATA`=0.
- Zero-wait transfer:
  - Accept at cycle 0.
  - SETUP at cycle 1.
  - ACCESS at cycle 2, with PREADY sampled high.
  - `RSP_VALID` at cycle 3.
  - IDLE at cycle 4, where the next request can be accepted.
  - Throughput is one transfer per 4 cycles.
- Each PREADY-low cycle in ACCESS adds one cycle of latency.
- Decode miss: accept at cycle 0, `RSP_VALID`+`RSP_ERR` at cycle 1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `APB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit-or-wider counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches `TIMEOUT_CYC` with PREADY still 0, the transfer aborts: go to RESP with `RSP_ERR`=1 and `RSP_RDATA`=0. PSEL and PENABLE drop in the RESP cycle.
  - PREADY=1 on the same cycle as the limit wins: normal completion.
- **Undefined:** no counter exists, and ACCESS waits indefinitely for PREADY.

## Test plan
- **Zero-wait write:** write to 0x4000_3010 with data 0xDEAD_BEEF. Expect PSEL=16'h0008, PADDR=0x4000_3010, PWDATA=0xDEAD_BEEF, PENABLE high in cycle 2, RSP_VALID in cycle 3, RSP_ERR=0.
- **Read with wait states:** read from 0x4000_F000 while slave 15 holds PREADY low for 3 cycles, then returns 0x1234_5678. Expect PSEL=16'h8000 stable throughout, RSP_RDATA=0x1234_5678 at cycle 6.
- **Decode miss:** request to 0x5000_0000. Expect PSEL to remain 0 and RSP_VALID+RSP_ERR one cycle after acceptance.
- **Slave error:** read with PSLVERR=1 and PRDATA=0xA5A5_A5A5. Expect RSP_ERR=1 and RSP_RDATA=0xA5A5_A5A5.
- **Reset mid-ACCESS:** assert PRST during a stalled ACCESS. Expect all outputs to drop to reset values asynchronously, no RSP_VALID, and the next request to complete normally.
- **Timeout (`APB_TIMEOUT_EN`, TIMEOUT_CYC=4):** hold PREADY at 0. Expect abort after 4 ACCESS cycles with RSP_ERR=1, RSP_RDATA=0, and PSEL=0.
